fifo_drain_ctrl: RTL

- Read-side controller for the team's synchronous FIFO.
- Pops the FIFO using its empty and error flags and accounts for the FIFO's 1-cycle read latency.
- Buffers popped words in a 2-entry skid buffer and presents them downstream on a valid/ready interface.
- Sits between the FIFO outputs and the consuming datapath; never pops a word it cannot store.

---
 rtl/fifo_drain_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: read-side controller for the synchronous FIFO.
// The FIFO returns data one cycle after it is popped. Popped words go into a
// 2-entry skid buffer and leave through a valid/ready port.
//
// Handshake: a word is transferred on any rising edge where valid_out and
// ready_in are both 1. valid_out does not depend on ready_in. While valid_out
// is 1, data_out stays stable until that word is transferred.
module fifo_drain_ctrl #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic              fifo_error,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [CNT_W-1:0]  words_out,
  output logic [1:0]        state_out,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            state;
  logic [1:0]        occ;       // words held in the skid buffer
  logic              inflight;  // a pop issued last cycle returns data now
  logic [DATA_W-1:0] tail_word; // second skid entry; data_out is the head
  logic              xfer;
  logic [2:0]        occ_proj;
  logic [1:0]        wr_pos;

  assign valid_out = (occ != 2'd0) & ~reset;
  assign xfer      = valid_out & ready_in;
  assign state_out = state;

  // Occupancy after this edge. A transfer only happens when occ >= 1,
  // so the result cannot go negative.
  assign occ_proj = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};

  // The returning word goes into the first free slot left after the head
  // is removed.
  assign wr_pos = occ - {1'b0, xfer};

  // Pop only when a free slot is guaranteed for the word one cycle later.
  assign fifo_read = ~reset & (state == RUN) & ~fifo_empty & ~fifo_error &
                     (occ_proj < 3'd2);

  // Control FSM and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      err   <= 1'b0;
    end else begin
      if (fifo_error && state != ERR) begin
        err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (fifo_error)  state <= ERR;
          else if (enable) state <= RUN;
        end
        RUN: begin
          if (fifo_error)   state <= ERR;
          else if (!enable) state <= STOP;
        end
        STOP: begin
          if (fifo_error)                          state <= ERR;
          else if (enable)                         state <= RUN;
          else if (occ == 2'd0 && !inflight)       state <= IDLE;
        end
        default: state <= ERR;
      endcase
    end
  end

  // Skid buffer, in-flight tracking and the transfer counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ       <= 2'd0;
      inflight  <= 1'b0;
      data_out  <= '0;
      tail_word <= '0;
      words_out <= '0;
    end else begin
      inflight <= fifo_read;
      occ      <= occ_proj[1:0];
      if (xfer) begin
        data_out  <= tail_word;
        words_out <= words_out + 1'b1;
      end
      if (inflight) begin
        if (wr_pos == 2'd0) data_out  <= fifo_data;
        else                tail_word <= fifo_data;
      end
    end
  end

endmodule
